path_arbiter: RTL and testbench

//  Grant side of the path req/gnt handshake. Collects req from NPATH path

---
 rtl/path_arbiter.sv | 138 +++++++++++++
 tb/tb_path_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/path_arbiter.sv
// Round-robin grant side of the path req/gnt handshake with a single registered output stage.
// Optional ARB_BURST_EN lets one path hold priority for up to BURST_LEN consecutive grants.
module path_arbiter #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned NPATH     = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPATH-1:0]          req_i,
    input  logic [NPATH*DWIDTH-1:0]   data_i,
    input  logic                      flush_i,
    input  logic                      ready_i,
    output logic [NPATH-1:0]          gnt_o,
    output logic                      valid_o,
    output logic [DWIDTH-1:0]         data_o,
    output logic [$clog2(NPATH)-1:0]  id_o
);

    localparam int unsigned IDW = $clog2(NPATH);

    logic              valid_q;
    logic [DWIDTH-1:0] data_q;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    ptr_d;
    logic [IDW-1:0]    ptr_inc;
    logic [IDW-1:0]    win_idx;
    logic              win_found;
    logic              load_en;

    assign load_en = (!valid_q || ready_i) && !flush_i;

    // Scan requests starting at ptr_q, wrapping round to find the first requester.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        idx       = 0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < int'(NPATH); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NPATH)) begin
                idx = idx - int'(NPATH);
            end
            cand = IDW'(idx);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign ptr_inc = (win_idx == IDW'(NPATH - 1)) ? '0 : win_idx + 1'b1;

    // Reset gating keeps gnt_o low while rst_n is asserted even though valid_q is 0.
    always_comb begin
        gnt_o = '0;
        if (rst_n && load_en && win_found) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

`ifdef ARB_BURST_EN
    localparam int unsigned BCW = $clog2(BURST_LEN + 1);

    logic [BCW-1:0] bcnt_q;
    logic [BCW-1:0] bcnt_d;

    always_comb begin
        ptr_d  = ptr_q;
        bcnt_d = bcnt_q;
        if (flush_i) begin
            ptr_d  = '0;
            bcnt_d = '0;
        end else if (load_en && !win_found) begin
            bcnt_d = '0;
        end else if (load_en) begin
            // valid_q marks an unbroken grant history for the current id_q.
            if (valid_q && win_idx == id_q && bcnt_q < BCW'(BURST_LEN - 1)) begin
                ptr_d  = win_idx;
                bcnt_d = bcnt_q + 1'b1;
            end else if ((!valid_q || win_idx != id_q) && BURST_LEN > 1) begin
                ptr_d  = win_idx;
                bcnt_d = BCW'(1);
            end else begin
                ptr_d  = ptr_inc;
                bcnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (load_en && win_found) begin
            ptr_d = ptr_inc;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (load_en) begin
                if (win_found) begin
                    valid_q <= 1'b1;
                    data_q  <= data_i[win_idx*DWIDTH +: DWIDTH];
                    id_q    <= win_idx;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign id_o    = id_q;

endmodule

// File: tb/tb_path_arbiter.sv
// Directed bench for path_arbiter: dut_a (BURST_LEN=1) covers round robin, backpressure,
// wrap, reset and flush; dut_b (BURST_LEN=4) covers burst or strict alternation.
module tb_path_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        flush;
    logic        ready;

    logic [3:0]  gnt_a;
    logic        valid_a;
    logic [7:0]  data_a;
    logic [1:0]  id_a;
    logic [3:0]  gnt_b;
    logic        valid_b;
    logic [7:0]  data_b;
    logic [1:0]  id_b;

    int total;
    int bad;

    path_arbiter #(.DWIDTH(8), .NPATH(4), .BURST_LEN(1)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .data_i  (data),
        .flush_i (flush),
        .ready_i (ready),
        .gnt_o   (gnt_a),
        .valid_o (valid_a),
        .data_o  (data_a),
        .id_o    (id_a)
    );

    path_arbiter #(.DWIDTH(8), .NPATH(4), .BURST_LEN(4)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .data_i  (data),
        .flush_i (flush),
        .ready_i (ready),
        .gnt_o   (gnt_b),
        .valid_o (valid_b),
        .data_o  (data_b),
        .id_o    (id_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_id,
                            input logic exp_valid);
        chk({tag, ".data"}, 32'(data_a), 32'(exp_data));
        chk({tag, ".id"}, 32'(id_a), 32'(exp_id));
        chk({tag, ".valid"}, 32'(valid_a), 32'(exp_valid));
    endtask

    initial begin
        int exp_k;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        flush = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        chk("rst.gnt", 32'(gnt_a), 32'h0);
        chk_word("rst", 8'h00, 2'd0, 1'b0);

        // Round robin over all four paths
        rst_n = 1'b1;
        ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr.gnt", 32'(gnt_a), 32'(4'b0001 << (i % 4)));
            tick();
            chk_word("rr", 8'hA0 + 8'(i % 4), 2'(i % 4), 1'b1);
        end

        // Backpressure holds the word and suppresses grants
        ready = 1'b0;
        req   = 4'b0110;
        #1;
        chk("bp.gnt", 32'(gnt_a), 32'h0);
        tick();
        chk_word("bp.hold", 8'hA0, 2'd0, 1'b1);
        ready = 1'b1;
        #1;
        chk("bp.release.gnt", 32'(gnt_a), 32'b0010);
        tick();
        chk_word("bp.load", 8'hA1, 2'd1, 1'b1);

        // Move ptr to 3, then sparse request wraps to path 0
        req = 4'b0100;
        #1;
        chk("wrap.pre.gnt", 32'(gnt_a), 32'b0100);
        tick();
        req = 4'b0101;
        #1;
        chk("wrap.gnt", 32'(gnt_a), 32'b0001);
        tick();
        chk_word("wrap.load", 8'hA0, 2'd0, 1'b1);
        chk("wrap.next.gnt", 32'(gnt_a), 32'b0100);
        tick();
        chk_word("wrap.next", 8'hA2, 2'd2, 1'b1);

        // Asynchronous reset mid-stream
        req   = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("midrst.gnt", 32'(gnt_a), 32'h0);
        chk_word("midrst", 8'h00, 2'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("midrst.first.gnt", 32'(gnt_a), 32'b0001);
        tick();
        chk_word("midrst.first", 8'hA0, 2'd0, 1'b1);

        // Flush dominates and resets priority to path 0
        req   = 4'b1000;
        flush = 1'b1;
        #1;
        chk("flush.gnt", 32'(gnt_a), 32'h0);
        tick();
        chk_word("flush", 8'hA0, 2'd0, 1'b0);
        flush = 1'b0;
        req   = 4'b1001;
        #1;
        chk("flush.after.gnt", 32'(gnt_a), 32'b0001);
        tick();
        chk_word("flush.after", 8'hA0, 2'd0, 1'b1);

        // No requests: valid drops, ptr holds at 1
        req = 4'b0000;
        #1;
        chk("idle.gnt", 32'(gnt_a), 32'h0);
        tick();
        chk_word("idle", 8'hA0, 2'd0, 1'b0);
        req = 4'b1111;
        #1;
        chk("idle.after.gnt", 32'(gnt_a), 32'b0010);

        // Burst behaviour on dut_b from a clean priority state
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req   = 4'b0011;
        for (int i = 0; i < 12; i++) begin
`ifdef ARB_BURST_EN
            exp_k = (i / 4) % 2;
`else
            exp_k = i % 2;
`endif
            #1;
            chk("burst.gnt", 32'(gnt_b), 32'(4'b0001 << exp_k));
            tick();
            chk("burst.id", 32'(id_b), 32'(exp_k));
            chk("burst.data", 32'(data_b), 32'(8'hA0 + 8'(exp_k)));
        end
        chk("burst.valid", 32'(valid_b), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
